// File: rtl/shift_unit_seq.sv
// Iterative LSL/LSR/ASR/ROR shifter, one bit position per cycle.
// Operands in and results out over valid/ready handshakes.
module shift_unit_seq #(
  parameter int N = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] shift_amount,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         carry,
  output logic         zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROR = 2'd3;

  localparam logic [N-1:0] NMAX = N'(N);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e        state_q;
  state_e        state_d;
  logic [N-1:0]  work_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          zero_q;

  logic [CW-1:0] eff;
  logic [N-1:0]  nxt;
  logic          cout;
  logic          accept;

  assign accept = in_valid && (state_q == IDLE);

  // Rotation wraps modulo N; the plain shifts saturate at N.
  always_comb begin
    eff = '0;
    if (mode == ROR) begin
      eff = CW'(shift_amount % NMAX);
    end else if (shift_amount >= NMAX) begin
      eff = CW'(N);
    end else begin
      eff = CW'(shift_amount);
    end
  end

  always_comb begin
    nxt  = work_q;
    cout = 1'b0;
    unique case (mode_q)
      LSL: begin
        nxt  = {work_q[N-2:0], 1'b0};
        cout = work_q[N-1];
      end
      LSR: begin
        nxt  = {1'b0, work_q[N-1:1]};
        cout = work_q[0];
      end
      ASR: begin
        nxt  = {work_q[N-1], work_q[N-1:1]};
        cout = work_q[0];
      end
      ROR: begin
        nxt  = {work_q[0], work_q[N-1:1]};
        cout = work_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      mode_q  <= LSL;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      work_q  <= data_in;
      mode_q  <= mode;
      cnt_q   <= eff;
      carry_q <= 1'b0;
      if (eff == '0) begin
        zero_q <= (data_in == '0);
      end
    end else if (state_q == SHIFT) begin
      work_q  <= nxt;
      carry_q <= cout;
      cnt_q   <= cnt_q - ONE;
      if (cnt_q == ONE) begin
        zero_q <= (nxt == '0);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = work_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule
